// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory req/ack bus (master = fetch unit, slave = memory)
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage owning PC/IR, fetches over imem req/ack and commits next PC on Buff_PC
// Ports: clk/Rst (sync, active-high); imem (req/addr out, ack/rdata in);
// controller inputs Buff_PC, Branch, Jump, JumpReg, Done; outputs Ins/InsM/InsL, PC, PCplus1,
// ins_valid, Stall, halted, instret.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        Rst,
  instr_fetch_unit_if.master imem,
  input  logic        Buff_PC,
  input  logic        Branch,
  input  logic [1:0]  Jump,
  input  logic [15:0] JumpReg,
  input  logic        Done,
  output logic [15:0] Ins,
  output logic [7:0]  InsM,
  output logic [1:0]  InsL,
  output logic [15:0] PC,
  output logic [15:0] PCplus1,
  output logic        ins_valid,
  output logic        Stall,
  output logic        halted,
  output logic [15:0] instret
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t      state_q;
  logic [15:0] pc_q, ir_q, instret_q, pc_d;
  logic        req_q, valid_q, halted_q;
  // Jump=11 is reserved and falls through to sequential, ignoring Branch
  always_comb
    pc_d = Jump == 2'b01 ? {pc_q[15:12], ir_q[11:0]} :
           Jump == 2'b10 ? JumpReg :
           (Jump == 2'b00 && Branch) ? pc_q + {{8{ir_q[7]}}, ir_q[7:0]} :
           pc_q + 16'd1;
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      instret_q <= 16'h0000;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: if (imem.imem_ack) begin
          ir_q    <= imem.imem_rdata;
          state_q <= EXEC;
          req_q   <= 1'b0;
          valid_q <= 1'b1;
        end
        EXEC: if (Done) begin
          state_q  <= HALT;
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
        end else if (Buff_PC) begin
          pc_q      <= pc_d;
          instret_q <= instret_q + 16'd1;
          state_q   <= FETCH;
          req_q     <= 1'b1;
          valid_q   <= 1'b0;
        end
        HALT: ;
      endcase
    end
  end
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign Ins            = ir_q;
  assign InsM           = ir_q[15:8];
  assign InsL           = ir_q[1:0];
  assign PC             = pc_q;
  assign PCplus1        = pc_q + 16'd1;
  assign ins_valid      = valid_q;
  assign Stall          = req_q;
  assign halted         = halted_q;
  assign instret        = instret_q;
endmodule
